// File: rtl/stream_demux.sv
// stream_demux: consumes the 48-bit memory-stream word {code, payload} every
// clock, tracks the BX from header words and regenerates per-port write
// strobes plus BX-paged write addresses for the 12 receiving memories.
// Optional BX sequence checking is enabled by defining BX_SEQ_CHECK_EN.
module stream_demux #(
  parameter int unsigned NPORTS = 12,
  parameter int unsigned DATA_W = 44,
  parameter int unsigned BX_W   = 3,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W+3:0]      stream_in,
  output logic [NPORTS-1:0]      wr_en,
  output logic [BX_W+ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_dat,
  output logic [BX_W-1:0]        cur_bx,
  output logic                   bx_valid,
  output logic                   new_bx,
  output logic [NPORTS-1:0]      overflow,
  output logic                   bad_code,
  output logic                   bx_skip
);

  localparam int unsigned PIDX_W = $clog2(NPORTS);

  typedef enum logic {WAIT_HDR, RUN} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]      cnt_q [NPORTS];
  logic [ADDR_W-1:0]      cnt_d [NPORTS];
  logic [NPORTS-1:0]      full_q, full_d;
  logic [NPORTS-1:0]      overflow_q, overflow_d;
  logic [BX_W-1:0]        cur_bx_q, cur_bx_d;
  logic                   bx_valid_q, bx_valid_d;
  logic                   new_bx_q, new_bx_d;
  logic                   bad_code_q, bad_code_d;
  logic [NPORTS-1:0]      wr_en_q, wr_en_d;
  logic [BX_W+ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_dat_q, wr_dat_d;

  logic [3:0]             code;
  logic [DATA_W-1:0]      payload;
  logic [BX_W-1:0]        hdr_bx;
  logic                   is_hdr;
  logic                   is_data;
  logic                   is_bad;
  logic [PIDX_W-1:0]      port_idx;

  assign code    = stream_in[DATA_W+3:DATA_W];
  assign payload = stream_in[DATA_W-1:0];
  assign hdr_bx  = payload[DATA_W-1 -: BX_W];

  // Decode the port code into header / data(port index) / illegal classes
  always_comb begin
    is_hdr   = 1'b0;
    is_data  = 1'b0;
    is_bad   = 1'b0;
    port_idx = '0;
    unique case (code)
      4'h0: ;
      4'hF: is_hdr = 1'b1;
      4'hA, 4'hE: is_bad = 1'b1;
      4'h9: begin is_data = 1'b1; port_idx = PIDX_W'(8);  end
      4'hB: begin is_data = 1'b1; port_idx = PIDX_W'(9);  end
      4'hC: begin is_data = 1'b1; port_idx = PIDX_W'(10); end
      4'hD: begin is_data = 1'b1; port_idx = PIDX_W'(11); end
      default: begin
        is_data  = 1'b1;
        port_idx = PIDX_W'(code - 4'd1);
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_HDR;
    else          state_q <= state_d;
  end

  // FSM next state: any header arms the block, nothing leaves RUN but reset
  always_comb begin
    state_d = state_q;
    if (is_hdr) state_d = RUN;
  end

  // Output/datapath next values: page bookkeeping, strobes and pulses
  always_comb begin
    cnt_d      = cnt_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    cur_bx_d   = cur_bx_q;
    bx_valid_d = bx_valid_q;
    new_bx_d   = 1'b0;
    bad_code_d = 1'b0;
    wr_en_d    = '0;
    wr_addr_d  = wr_addr_q;
    wr_dat_d   = wr_dat_q;
    if (is_hdr) begin
      cur_bx_d   = hdr_bx;
      bx_valid_d = 1'b1;
      new_bx_d   = 1'b1;
      for (int unsigned i = 0; i < NPORTS; i++) cnt_d[i] = '0;
      full_d     = '0;
      overflow_d = '0;
    end else if (state_q == RUN) begin
      if (is_bad) begin
        bad_code_d = 1'b1;
      end else if (is_data) begin
        if (full_q[port_idx]) begin
          overflow_d[port_idx] = 1'b1;
        end else begin
          wr_en_d[port_idx] = 1'b1;
          wr_addr_d         = {cur_bx_q, cnt_q[port_idx]};
          wr_dat_d          = payload;
          // the last entry of the page marks it full rather than wrapping
          if (cnt_q[port_idx] == '1) full_d[port_idx] = 1'b1;
          cnt_d[port_idx] = cnt_q[port_idx] + ADDR_W'(1);
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
      full_q     <= '0;
      overflow_q <= '0;
      cur_bx_q   <= '0;
      bx_valid_q <= 1'b0;
      new_bx_q   <= 1'b0;
      bad_code_q <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_dat_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      cur_bx_q   <= cur_bx_d;
      bx_valid_q <= bx_valid_d;
      new_bx_q   <= new_bx_d;
      bad_code_q <= bad_code_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_dat_q   <= wr_dat_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_dat   = wr_dat_q;
  assign cur_bx   = cur_bx_q;
  assign bx_valid = bx_valid_q;
  assign new_bx   = new_bx_q;
  assign overflow = overflow_q;
  assign bad_code = bad_code_q;

`ifdef BX_SEQ_CHECK_EN
  logic [BX_W-1:0] bx_next;
  logic            bx_skip_q, bx_skip_d;

  assign bx_next   = cur_bx_q + BX_W'(1);
  // only headers seen while in RUN have a predecessor to compare against
  assign bx_skip_d = is_hdr && (state_q == RUN) && (hdr_bx != bx_next);

  // Register the sequence-skip pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bx_skip_q <= 1'b0;
    else          bx_skip_q <= bx_skip_d;
  end

  assign bx_skip = bx_skip_q;
`else
  assign bx_skip = 1'b0;
`endif

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Downstream stage of the memory-stream mux; consumes its 48-bit stream word {sel[3:0], payload[43:0]} on every clock.
- Decodes the 4-bit port code and tracks the BX from header words.
- Regenerates per-port write strobes and BX-paged write addresses into the 12 receiving memories.
- One word per cycle, no back-pressure.

Parameters:
NPORTS, 12, number of destination memories (fixed code map below assumes 12)
DATA_W, 44, payload width
BX_W, 3, BX field width
ADDR_W, 6, per-BX entry address width (64 entries per BX page per port)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
stream_in  in  48  {code[47:44], payload[43:0]}; header payload carries BX in [43:41]
wr_en  out  NPORTS  one-hot write strobe, bit i = memory i
wr_addr  out  BX_W+ADDR_W  {cur_bx, entry index} for the strobed port
wr_dat  out  DATA_W  payload, shared by all ports
cur_bx  out  BX_W  BX from the last header
bx_valid  out  1  high once a header has been received since reset
new_bx  out  1  one-cycle pulse on header acceptance
overflow  out  NPORTS  sticky per-port page-full drop flag, cleared by header
bad_code  out  1  one-cycle pulse on an illegal code
bx_skip  out  1  one-cycle pulse on a non-consecutive BX (optional feature)

Behaviour:
- Code map:
  - 1111 = header.
  - 0000 = idle.
  - 0001..1000 = ports 0..7.
  - 1001 = port 8.
  - 1011 = port 9.
  - 1100 = port 10.
  - 1101 = port 11.
  - 1010 and 1110 are illegal.
- Reset: all outputs 0, all counters 0, full flags 0, state WAIT_HDR; asynchronous assert, synchronous release.
- All outputs are registered. stream_in sampled at edge N produces wr_en/wr_addr/wr_dat/pulses valid after edge N (1-cycle latency).
- State WAIT_HDR:
  - Data and illegal words are discarded: no wr_en, no bad_code.
  - Header -> RUN.
- State RUN: stays in RUN until reset.
- Header, in either state:
  - cur_bx <= payload[43:41]; bx_valid <= 1; new_bx pulses.
  - All NPORTS counters and full flags cleared; overflow cleared.
- Data word for port i in RUN:
  - If full[i]=0: wr_en[i]=1 for one cycle, wr_addr={cur_bx, cnt[i]}, wr_dat=payload, then cnt[i]++.
  - When cnt[i] wraps from 2^ADDR_W-1, set full[i] instead of wrapping.
  - If full[i]=1: word dropped; overflow[i] <= 1 (sticky).
- Idle word: wr_en=0; wr_addr/wr_dat hold their last value.
- Illegal code in RUN: bad_code pulses; no write; counters unchanged.
- Back-to-back headers are legal; each restarts the page.
- Reset mid-page: all state lost; writes resume only after the next header.

Optional Feature:
- Macro BX_SEQ_CHECK_EN.
- Defined: on a header in RUN, bx_skip pulses if payload BX != (cur_bx+1) mod 2^BX_W. The first header after reset never flags. The header is still accepted normally.
- Undefined: bx_skip tied 0; no comparator logic.

Test Plan:
- Reset, then send 0x1_00000000001 (port 0, no header) -> wr_en=0. Send header code F, BX=5, then 0x2_...AB -> wr_en=0x002, wr_addr={3'd5, 6'd0}, wr_dat=...AB one cycle later; new_bx pulsed one cycle after the header.
- After header BX=2, send 3 words each to port 9 (code B) and port 11 (code D), interleaved -> port 9 addrs {2,0},{2,1},{2,2}; port 11 addrs {2,0},{2,1},{2,2}; wr_en one-hot each cycle.
- Send 65 words to port 3 (code 4) in one BX -> 64 writes, addrs 0..63; 65th dropped, overflow[3]=1. Next header -> overflow=0; port 3 restarts at addr 0.
- Send codes A, E, then 0 -> bad_code pulses twice, wr_en stays 0, counters unchanged.
- With BX_SEQ_CHECK_EN defined: headers BX 6, 7, 0, 2 -> bx_skip pulses only on BX 2; build without the macro -> bx_skip constant 0.
- Assert reset_n low mid-stream after 10 writes to port 1 -> outputs 0 immediately. Release, send header BX=1 -> port 1 restarts at addr {1,0}.
